// File: rtl/button_conditioner.sv
// Per-channel synchroniser + debouncer producing a clean level and 1-cycle press/release pulses.
// Optional anti-mash rejection of simultaneous presses under BTN_MULTI_REJECT_EN.
module button_conditioner #(
  parameter int unsigned N_BTN           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
`ifdef SIMULATION
  parameter int unsigned DEBOUNCE_CYCLES = 4
`else
  parameter int unsigned DEBOUNCE_CYCLES = 1000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press,
  output logic             multi_press
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] synced;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] press_d;
  logic             multi_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
      end
    end

    assign synced[i] = sync_q[SYNC_STAGES-1];
    assign accept[i] = (synced[i] != lvl_q) && (cnt_q == CNT_MAX);

    // Counter only runs while synced disagrees with the level; any agreeing
    // sample restarts it, so a short glitch never accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (synced[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_q <= synced[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign level_q[i] = lvl_q;
  end

  assign rise = accept & synced;
  assign fall = accept & ~synced;

  always_comb begin
    press_d = rise;
    multi_d = 1'b0;
`ifdef BTN_MULTI_REJECT_EN
    // Two or more bits set <=> clearing the lowest set bit leaves a non-zero value.
    if ((rise & (rise - N_BTN'(1))) != '0) begin
      press_d = '0;
      multi_d = 1'b1;
    end
`endif
  end

  // Pulses are registered on the same edge that updates the level, so they
  // line up with the first cycle the new level is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      btn_press   <= press_d;
      btn_release <= fall;
      any_press   <= |press_d;
      multi_press <= multi_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing, checked
// against a sliding-window debounce model of the raw input history.
module tb_button_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] btn_raw = '0;
  logic [7:0] btn_level;
  logic [7:0] btn_press;
  logic [7:0] btn_release;
  logic       any_press;
  logic       multi_press;

  int tests = 0;
  int fails = 0;

  logic [7:0] hist[$];
  logic [7:0] m_level, m_press, m_release;
  logic       m_any, m_multi;

  button_conditioner #(
    .N_BTN(8),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_press(any_press),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + D; i++) hist.push_back(8'h00);
    m_level = '0; m_press = '0; m_release = '0; m_any = 1'b0; m_multi = 1'b0;
  endtask

  // Level flips when the last D synchronised samples (raw delayed by S edges)
  // all disagree with the current level.
  task automatic model_edge();
    logic [7:0] rise, fall, h, tmp;
    bit         all_diff;
    int         n;
    hist.push_front(btn_raw);
    tmp = hist.pop_back();
    rise = '0; fall = '0;
    for (int ch = 0; ch < 8; ch++) begin
      all_diff = 1'b1;
      for (int k = S; k < S + D; k++) begin
        h = hist[k];
        if (h[ch] == m_level[ch]) all_diff = 1'b0;
      end
      if (all_diff) begin
        if (m_level[ch]) fall[ch] = 1'b1;
        else             rise[ch] = 1'b1;
      end
    end
    m_level   = m_level ^ (rise | fall);
    m_release = fall;
    m_press   = rise;
    m_multi   = 1'b0;
`ifdef BTN_MULTI_REJECT_EN
    n = 0;
    for (int ch = 0; ch < 8; ch++) n += int'(rise[ch]);
    if (n >= 2) begin
      m_press = '0;
      m_multi = 1'b1;
    end
`else
    n = 0;
`endif
    m_any = (m_press != 8'h00);
  endtask

  task automatic check_model();
    check("level",   btn_level,   m_level);
    check("press",   btn_press,   m_press);
    check("release", btn_release, m_release);
    check("any",     {7'd0, any_press},   {7'd0, m_any});
    check("multi",   {7'd0, multi_press}, {7'd0, m_multi});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_model();
  endtask

  task automatic settle(input logic [7:0] v);
    btn_raw = v;
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    int press_edge;
    logic [7:0] seq[6];
    logic [7:0] mask;

    // 1: reset held with all buttons down
    model_reset();
    btn_raw = 8'hFF;
    #1;
    check_model();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e < 6) check("t1_level_early", btn_level, 8'h00);
      if (e == 6) begin
        check("t1_level", btn_level, 8'hFF);
`ifdef BTN_MULTI_REJECT_EN
        check("t1_press", btn_press, 8'h00);
`else
        check("t1_press", btn_press, 8'hFF);
`endif
      end
      if (e == 7) check("t1_press_width", btn_press, 8'h00);
    end

    // 2: single press on channel 3
    settle(8'h00);
    btn_raw = 8'h08;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 5) check("t2_level_early", btn_level, 8'h00);
      if (e == 6) begin
        check("t2_press", btn_press, 8'h08);
        check("t2_any", {7'd0, any_press}, 8'h01);
      end
      if (e == 7) check("t2_press_width", btn_press, 8'h00);
    end

    // 3: glitch shorter than the debounce window
    settle(8'h00);
    btn_raw = 8'h08;
    for (int e = 0; e < 3; e++) step();
    btn_raw = 8'h00;
    press_edge = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (btn_press != 8'h00) press_edge++;
    end
    check("t3_level", btn_level, 8'h00);
    check("t3_npress", 8'(press_edge), 8'h00);

    // 4: bounce 1,0,1,1,1,1 then hold
    seq = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08};
    press_edge = 0;
    mask = 8'h00;
    for (int e = 1; e <= 14; e++) begin
      btn_raw = (e <= 6) ? seq[e-1] : 8'h08;
      step();
      if (btn_press[3]) begin
        press_edge = e;
        mask = mask + 8'h01;
      end
    end
    check("t4_npress", mask, 8'h01);
    check("t4_press_edge", 8'(press_edge), 8'd8);

    // 5: release of channel 5
    settle(8'h28);
    check("t5_level_pre", btn_level, 8'h28);
    btn_raw = 8'h08;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) begin
        check("t5_release", btn_release, 8'h20);
        check("t5_press", btn_press, 8'h00);
      end
      if (e == 7) check("t5_release_width", btn_release, 8'h00);
    end

    // 6: simultaneous press on channels 0 and 6
    settle(8'h00);
    btn_raw = 8'h41;
    for (int e = 1; e <= 6; e++) step();
    check("t6_level", btn_level, 8'h41);
`ifdef BTN_MULTI_REJECT_EN
    check("t6_press", btn_press, 8'h00);
    check("t6_multi", {7'd0, multi_press}, 8'h01);
`else
    check("t6_press", btn_press, 8'h41);
    check("t6_multi", {7'd0, multi_press}, 8'h00);
`endif

    // Reset mid-debounce with buttons held through release
    settle(8'h00);
    btn_raw = 8'h81;
    for (int e = 0; e < 3; e++) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    for (int e = 0; e < 2; e++) step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) check("rst_level_early", btn_level, 8'h00);
    end
    check("rst_level", btn_level, 8'h81);

    // Random bouncing on sparse channels
    for (int i = 0; i < 600; i++) begin
      mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 2) == 0) btn_raw = btn_raw ^ mask;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
